register_file_sb: RTL and testbench
===================================

# register_file_sb

Parametrised, pipelined successor to the 8×16 ANNA register file. It has two read ports with a one-cycle registered read and write-first forwarding, and one write port. A per-register busy scoreboard lets the decode stage reserve a destination register at issue and have writeback release it. It sits between decode (read and reserve) and writeback (write) in the pipelined ANNA core.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- NREGS, 8, number of registers (≥2)
- ADDR_W, $clog2(NREGS), register address width
- ZERO_REG, 1, when 1 register 0 reads as 0 and is never written or reserved

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- r_en1  in  1  read enable, port 1
- ra1  in  ADDR_W  read address, port 1
- r_data1  out  DATA_W  registered read data, port 1
- r_busy1  out  1  registered busy bit of ra1, port 1
- r_en2  in  1  read enable, port 2
- ra2  in  ADDR_W  read address, port 2
- r_data2  out  DATA_W  registered read data, port 2
- r_busy2  out  1  registered busy bit of ra2, port 2
- w_en  in  1  write enable
- wa  in  ADDR_W  write address
- w_data  in  DATA_W  write data
- rsv_en  in  1  reserve enable: mark rsv_addr busy
- rsv_addr  in  ADDR_W  register to reserve
- busy_mask  out  NREGS  current scoreboard, one bit per register; bit i is register i

## Operation
- Storage: NREGS × DATA_W registers and an NREGS-bit busy vector.
- Reset (reset=0, asynchronous) clears every register, every busy bit, r_data1/2 and r_busy1/2 to 0, immediately and regardless of clk.
- Write: on an edge with w_en=1, the register at wa takes w_data and busy[wa] clears.
- Reserve: on an edge with rsv_en=1, busy[rsv_addr] sets.
- Reserve and write to the same address on the same edge: the data is written and busy stays 1, because the reserve belongs to a newer producer.
- Reserve and write to different addresses on the same edge: both updates apply.
- Read: on an edge with r_enN=1, r_dataN is loaded from register raN, and r_busyN is loaded from busy[raN].
- Forwarding (write-first): if w_en=1 and wa==raN on the same edge, r_dataN gets w_data rather than the old contents.
- Busy forwarding: r_busyN takes the post-update value of busy[raN], after the same edge's write-clear and reserve-set are applied.
- Read disabled: with r_enN=0, r_dataN and r_busyN hold their previous values.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - Reserves to address 0 are dropped.
  - Reads of address 0 return 0 with busy 0, with no forwarding from a write to address 0.
- Out-of-range addresses (≥NREGS when NREGS is not a power of 2):
  - Writes and reserves are ignored.
  - Reads return 0 with busy 0.
- busy_mask is a direct combinational view of the busy vector.

## Timing
- Read latency: 1 cycle. Address is sampled at edge N; data and busy are valid after edge N and stable until the next enabled read.
- Write latency: 0 cycles to the read ports through forwarding. The array and busy_mask update at the edge.
- Reserve latency: busy_mask bit rises after the edge, and a same-edge read of that address already reports busy.
- No handshake and no stalls: every edge accepts one write, one reserve and two reads.
- Reset asserted mid-operation aborts everything. The first edge after reset deasserts sees an all-zero, all-idle file.

## Test plan
- Reset: pulse reset low between clock edges.
  - All registers, busy_mask, r_data1/2 and r_busy1/2 read 0 immediately, with no clock edge needed.
- Write/read:
  - Write 0x0102 to r1, then 0x0506 to r2.
  - Read ra1=1, ra2=2 → after one edge, r_data1=0x0102 and r_data2=0x0506.
- Forwarding:
  - Same edge: w_en with wa=3, w_data=0x0304, plus a read of ra1=3.
  - After that edge: r_data1=0x0304.
  - With r_en1=0 on the next cycle, r_data1 holds 0x0304.
- Zero register (ZERO_REG=1): write 0xFFFF to r0 and reserve r0.
  - A read of r0 returns 0 with busy 0; busy_mask[0]=0.
- Scoreboard:
  - Reserve r4 → busy_mask=0x10, and a read of r4 gives r_busy=1.
  - Write 0x0A0A to r4 → busy_mask=0x00, and a read gives 0x0A0A with busy 0.
- Simultaneous events:
  - Reserve r5 and write r5=0x5555 on one edge → busy_mask[5]=1 and a read gives 0x5555 with busy 1.
  - Reset mid-sequence → everything returns to 0.

Source files
------------

// File: rtl/register_file_sb.sv
// Two-read / one-write register file with registered write-first reads and a
// per-register busy scoreboard (reserve at issue, release on writeback).
module register_file_sb #(
    parameter int DATA_W   = 16,
    parameter int NREGS    = 8,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r_en1,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] r_data1,
    output logic              r_busy1,
    input  logic              r_en2,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] r_data2,
    output logic              r_busy2,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] w_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [NREGS-1:0]  busy_mask
);

    localparam logic [ADDR_W:0] NREGS_W = (ADDR_W + 1)'(NREGS);

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREGS_W);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic              wr_ok;
    logic              rsv_ok;

    assign wr_ok  = w_en   && addr_ok(wa)       && !is_zero_reg(wa);
    assign rsv_ok = rsv_en && addr_ok(rsv_addr) && !is_zero_reg(rsv_addr);

    // Reserve is applied after the write-clear so a same-edge newer producer wins.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            mem_d[i] = mem_q[i];
        end
        busy_d = busy_q;
        if (wr_ok) begin
            mem_d[wa]  = w_data;
            busy_d[wa] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_mask = busy_q;

    logic              r_en_a   [2];
    logic [ADDR_W-1:0] ra_a     [2];
    logic [DATA_W-1:0] r_data_a [2];
    logic              r_busy_a [2];

    assign r_en_a[0] = r_en1;
    assign r_en_a[1] = r_en2;
    assign ra_a[0]   = ra1;
    assign ra_a[1]   = ra2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] r_data_q;
            logic [DATA_W-1:0] r_data_d;
            logic              r_busy_q;
            logic              r_busy_d;

            // Reading the post-update view gives write-first data and busy forwarding.
            always_comb begin
                r_data_d = r_data_q;
                r_busy_d = r_busy_q;
                if (r_en_a[gi]) begin
                    if (addr_ok(ra_a[gi])) begin
                        r_data_d = mem_d[ra_a[gi]];
                        r_busy_d = busy_d[ra_a[gi]];
                    end else begin
                        r_data_d = '0;
                        r_busy_d = 1'b0;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_data_q <= '0;
                    r_busy_q <= 1'b0;
                end else begin
                    r_data_q <= r_data_d;
                    r_busy_q <= r_busy_d;
                end
            end

            assign r_data_a[gi] = r_data_q;
            assign r_busy_a[gi] = r_busy_q;
        end
    endgenerate

    assign r_data1 = r_data_a[0];
    assign r_busy1 = r_busy_a[0];
    assign r_data2 = r_data_a[1];
    assign r_busy2 = r_busy_a[1];

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: hand-computed expectations for reads,
// forwarding, zero register, scoreboard and asynchronous reset.
module tb_register_file_sb;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              r_en1, r_en2, w_en, rsv_en;
    logic [ADDR_W-1:0] ra1, ra2, wa, rsv_addr;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] r_data1, r_data2;
    logic              r_busy1, r_busy2;
    logic [NREGS-1:0]  busy_mask;

    int total = 0;
    int bad   = 0;

    register_file_sb #(
        .DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W), .ZERO_REG(1)
    ) dut (
        .clk(clk), .reset(reset),
        .r_en1(r_en1), .ra1(ra1), .r_data1(r_data1), .r_busy1(r_busy1),
        .r_en2(r_en2), .ra2(ra2), .r_data2(r_data2), .r_busy2(r_busy2),
        .w_en(w_en), .wa(wa), .w_data(w_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic idle();
        r_en1 = 0; r_en2 = 0; w_en = 0; rsv_en = 0;
        ra1 = '0; ra2 = '0; wa = '0; rsv_addr = '0; w_data = '0;
    endtask

    // One rising edge, then settle on the falling edge for checks and new inputs.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #1;
        check_val("rst_data1", 32'(r_data1), 32'h0);
        check_val("rst_busy1", 32'(r_busy1), 32'h0);
        check_val("rst_mask",  32'(busy_mask), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Plain writes then a dual read
        w_en = 1; wa = 3'd1; w_data = 16'h0102; cycle();
        wa = 3'd2; w_data = 16'h0506; cycle();
        idle(); r_en1 = 1; ra1 = 3'd1; r_en2 = 1; ra2 = 3'd2; cycle();
        check_val("rd_r1", 32'(r_data1), 32'h0102);
        check_val("rd_r2", 32'(r_data2), 32'h0506);
        check_val("rd_busy1", 32'(r_busy1), 32'h0);

        // Write-first forwarding, then hold with read disabled
        idle(); w_en = 1; wa = 3'd3; w_data = 16'h0304; r_en1 = 1; ra1 = 3'd3; cycle();
        check_val("fwd_r3", 32'(r_data1), 32'h0304);
        check_val("hold_p2", 32'(r_data2), 32'h0506);
        idle(); ra1 = 3'd1; cycle();
        check_val("hold_p1", 32'(r_data1), 32'h0304);

        // Zero register: write, reserve and same-edge read of r0
        idle(); w_en = 1; wa = 3'd0; w_data = 16'hFFFF; rsv_en = 1; rsv_addr = 3'd0;
        r_en1 = 1; ra1 = 3'd0; cycle();
        check_val("zr_nofwd", 32'(r_data1), 32'h0);
        check_val("zr_mask", 32'(busy_mask), 32'h0);
        idle(); r_en1 = 1; ra1 = 3'd0; r_en2 = 1; ra2 = 3'd1; cycle();
        check_val("zr_read", 32'(r_data1), 32'h0);
        check_val("zr_busy", 32'(r_busy1), 32'h0);
        check_val("r1_kept", 32'(r_data2), 32'h0102);

        // Scoreboard reserve / release
        idle(); rsv_en = 1; rsv_addr = 3'd4; r_en2 = 1; ra2 = 3'd4; cycle();
        check_val("rsv_mask", 32'(busy_mask), 32'h10);
        check_val("rsv_fwd_busy2", 32'(r_busy2), 32'h1);
        idle(); r_en1 = 1; ra1 = 3'd4; cycle();
        check_val("rsv_busy1", 32'(r_busy1), 32'h1);
        idle(); w_en = 1; wa = 3'd4; w_data = 16'h0A0A; r_en1 = 1; ra1 = 3'd4; cycle();
        check_val("rel_mask", 32'(busy_mask), 32'h0);
        check_val("rel_data", 32'(r_data1), 32'h0A0A);
        check_val("rel_busy", 32'(r_busy1), 32'h0);
        check_val("busy2_hold", 32'(r_busy2), 32'h1);

        // Same-address reserve + write: data lands, busy stays set
        idle(); rsv_en = 1; rsv_addr = 3'd5; w_en = 1; wa = 3'd5; w_data = 16'h5555;
        r_en1 = 1; ra1 = 3'd5; cycle();
        check_val("sim_mask", 32'(busy_mask), 32'h20);
        check_val("sim_data", 32'(r_data1), 32'h5555);
        check_val("sim_busy", 32'(r_busy1), 32'h1);

        // Different-address reserve + write both apply
        idle(); rsv_en = 1; rsv_addr = 3'd6; w_en = 1; wa = 3'd1; w_data = 16'h1111;
        r_en2 = 1; ra2 = 3'd6; cycle();
        check_val("diff_mask", 32'(busy_mask), 32'h60);
        check_val("diff_busy2", 32'(r_busy2), 32'h1);
        idle(); r_en1 = 1; ra1 = 3'd1; cycle();
        check_val("diff_r1", 32'(r_data1), 32'h1111);

        // Asynchronous reset mid-sequence, between edges
        idle();
        #2 reset = 1'b0;
        #1;
        check_val("mid_rst_d1", 32'(r_data1), 32'h0);
        check_val("mid_rst_b2", 32'(r_busy2), 32'h0);
        check_val("mid_rst_mask", 32'(busy_mask), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        r_en1 = 1; ra1 = 3'd1; r_en2 = 1; ra2 = 3'd5; cycle();
        check_val("post_rst_r1", 32'(r_data1), 32'h0);
        check_val("post_rst_r5", 32'(r_data2), 32'h0);
        check_val("post_rst_b5", 32'(r_busy2), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
